pause_ctrl_mc: RTL

Multi-source, parametrised pause controller for the Pocket platform interface layer. It merges the OS menu status with up to NUM_REQ core-side pause requests through per-source synchronisers and a runtime enable mask. Pause entry and exit can optionally be aligned to vertical blanking, and a minimum pause hold time is enforced. The block drives the core-wide pause signal and reports which sources are responsible for the pause.

---
 rtl/pause_ctrl_mc.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pause_ctrl_mc.sv
// Pause controller: merges the OS menu flag with masked core pause requests,
// optionally aligns pause entry/exit to vblank, and enforces a minimum pause time.
module pause_ctrl_mc #(
    parameter int NUM_REQ      = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int ALIGN_VBLANK = 1,
    parameter int MIN_HOLD     = 16,
    parameter int VBL_TIMEOUT  = 1000000
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               os_inmenu,
    input  logic [NUM_REQ-1:0] pause_req,
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic               vblank,
    output logic               pause_core,
    output logic               pause_pending,
    output logic [NUM_REQ:0]   pause_src
);

    localparam int HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int TMR_W  = (VBL_TIMEOUT > 0) ? $clog2(VBL_TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
    localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(VBL_TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((VBL_TIMEOUT > 0) ? VBL_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_IN  = 2'd1,
        PAUSED   = 2'd2,
        WAIT_OUT = 2'd3
    } state_t;

    state_t state, state_next;

    // One shared synchroniser chain: {vblank, os_inmenu, pause_req}.
    logic [NUM_REQ+1:0] sync_chain [SYNC_STAGES];
    logic [NUM_REQ-1:0] req_s;
    logic               inmenu_s;
    logic               vbl_s;
    logic               vbl_d;
    logic               vbl_rise;
    logic [NUM_REQ:0]   src_v;
    logic               want;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [TMR_W-1:0]   wait_cnt;
    logic               hold_done;
    logic               timeout;
    logic               wait_now;
    logic               wait_next;
    logic               paused_next;

    assign req_s    = sync_chain[SYNC_STAGES-1][NUM_REQ-1:0];
    assign inmenu_s = sync_chain[SYNC_STAGES-1][NUM_REQ];
    assign vbl_s    = sync_chain[SYNC_STAGES-1][NUM_REQ+1];

    assign src_v = {inmenu_s, req_s & req_mask};
    assign want  = |src_v;

    // The hold counter saturates at MIN_HOLD, so equality is the ">=" test.
    assign hold_done = (hold_cnt == HOLD_MAX);
    assign timeout   = (VBL_TIMEOUT != 0) && (wait_cnt == TMR_LAST);

    assign wait_now    = (state == WAIT_IN) || (state == WAIT_OUT);
    assign wait_next   = (state_next == WAIT_IN) || (state_next == WAIT_OUT);
    assign paused_next = (state_next == PAUSED) || (state_next == WAIT_OUT);

    // NOTE: state is stored with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= '0;
            end
            vbl_d <= 1'b0;
        end else begin
            sync_chain[0] <= {vblank, os_inmenu, pause_req};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
            vbl_d <= vbl_s;
        end
    end

    // The edge detect is registered, giving a vblank-to-pause latency of SYNC_STAGES+2.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vbl_rise <= 1'b0;
        end else begin
            vbl_rise <= vbl_s & ~vbl_d;
        end
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (want) begin
                    if (ALIGN_VBLANK != 0) state_next = WAIT_IN;
                    else                   state_next = PAUSED;
                end
            end
            WAIT_IN: begin
                // An abort takes priority over a coincident vblank edge.
                if (!want)                    state_next = RUN;
                else if (vbl_rise || timeout) state_next = PAUSED;
            end
            PAUSED: begin
                if (!want && hold_done) begin
                    if (ALIGN_VBLANK != 0) state_next = WAIT_OUT;
                    else                   state_next = RUN;
                end
            end
            WAIT_OUT: begin
                // A returning request keeps the core paused even on a vblank edge.
                if (want)                     state_next = PAUSED;
                else if (vbl_rise || timeout) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state         <= RUN;
            hold_cnt      <= '0;
            wait_cnt      <= '0;
            pause_core    <= 1'b0;
            pause_pending <= 1'b0;
            pause_src     <= '0;
        end else begin
            state <= state_next;

            // Re-entering PAUSED from WAIT_OUT keeps the accumulated hold time.
            if (state_next == PAUSED && (state == RUN || state == WAIT_IN)) begin
                hold_cnt <= '0;
            end else if ((state == PAUSED || state == WAIT_OUT) && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end

            if (wait_next && state_next != state) begin
                wait_cnt <= '0;
            end else if (wait_now && wait_cnt != TMR_MAX) begin
                wait_cnt <= wait_cnt + TMR_W'(1);
            end

            pause_core    <= paused_next;
            pause_pending <= wait_next;
            pause_src     <= paused_next ? src_v : '0;
        end
    end

endmodule
